store_size_unit: RTL and testbench

Data-memory write stage that sits directly downstream of the multicycle control unit. It consumes the store-size code (`tam`), the store strobe, the ALUOut address and the regB write data. It performs a read-modify-write on the 64-bit doubleword memory so that sw, sh and sb update only their byte lanes, while sd is written directly. It reports completion and misalignment back to the control sequencer.

---
 rtl/store_pkg.sv | 54 +++++
 rtl/store_size_unit_if.sv | 29 ++
 rtl/store_merge.sv | 27 ++
 rtl/store_size_unit.sv | 100 ++++++++++
 tb/tb_store_size_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared types and byte-lane helpers for the store-size write stage.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_D = 2'b00,
    SZ_W = 2'b01,
    SZ_H = 2'b10,
    SZ_B = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    ERR  = 2'b11
  } state_e;

  localparam int unsigned CntW = 3;

  // Index of the lowest byte lane touched by a store of this size.
  function automatic logic [2:0] lane_base(size_e sz, logic [2:0] off);
    logic [2:0] base;
    unique case (sz)
      SZ_D:    base = 3'd0;
      SZ_W:    base = {off[2], 2'b00};
      SZ_H:    base = {off[2:1], 1'b0};
      default: base = off;
    endcase
    return base;
  endfunction

  function automatic logic [7:0] byte_mask(size_e sz, logic [2:0] off);
    logic [7:0] width_mask;
    unique case (sz)
      SZ_D:    width_mask = 8'hFF;
      SZ_W:    width_mask = 8'h0F;
      SZ_H:    width_mask = 8'h03;
      default: width_mask = 8'h01;
    endcase
    return width_mask << lane_base(sz, off);
  endfunction

  function automatic logic is_misaligned(size_e sz, logic [2:0] off);
    logic bad;
    unique case (sz)
      SZ_D:    bad = |off;
      SZ_W:    bad = |off[1:0];
      SZ_H:    bad = off[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_size_unit_if.sv
// Request and data-memory signals of the store-size write stage.
interface store_size_unit_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              start;
  logic [1:0]        tam;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              misalign;

  // Sequencer plus memory side.
  modport master (
    output start, tam, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, misalign
  );

  // Store unit side.
  modport slave (
    input  start, tam, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, misalign
  );
endinterface

// File: rtl/store_merge.sv
// Combinational little-endian byte-lane merge of store data into the old doubleword.
module store_merge
  import store_pkg::*;
(
  input  size_e       size_i,
  input  logic [2:0]  offset_i,
  input  logic [63:0] old_i,
  input  logic [63:0] new_i,
  output logic [63:0] merged_o
);

  logic [7:0]  mask;
  logic [63:0] shifted;

  always_comb begin
    mask     = byte_mask(size_i, offset_i);
    // Store data sits in the low bytes; move it up to the first target lane.
    shifted  = new_i << {lane_base(size_i, offset_i), 3'b000};
    merged_o = old_i;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        merged_o[8*i +: 8] = shifted[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/store_size_unit.sv
// Store-size write stage: read-modify-write for sw/sh/sb, direct write for sd.
module store_size_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  store_size_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_q, old_d;
  size_e             size_q, size_d;
  logic [DATA_W-1:0] merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      size_q  <= SZ_D;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    size_d  = size_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          size_d  = size_e'(bus.tam);
          if (is_misaligned(size_e'(bus.tam), bus.addr[2:0])) begin
            state_d = ERR;
          end else if (size_e'(bus.tam) == SZ_D) begin
            state_d = WR;
          end else begin
            state_d = RD;
            cnt_d   = CntW'(1);
          end
        end
      end
      RD: begin
        if (cnt_q == CntW'(MEM_RD_LAT)) begin
          old_d   = bus.mem_rdata;
          state_d = WR;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sd also goes through the merge: its mask covers all eight lanes.
  store_merge u_merge (
    .size_i   (size_q),
    .offset_i (addr_q[2:0]),
    .old_i    (old_q),
    .new_i    (wdata_q),
    .merged_o (merged)
  );

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.mem_we    = (state_q == WR);
    bus.done      = (state_q == WR) || (state_q == ERR);
    bus.misalign  = (state_q == ERR);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if ((state_q == RD) || (state_q == WR)) begin
      bus.mem_addr = {addr_q[ADDR_W-1:3], 3'b000};
    end
    if (state_q == WR) begin
      bus.mem_wdata = merged;
    end
  end

endmodule

// File: tb/tb_store_size_unit.sv
// Directed bench for store_size_unit at read latencies 1 and 3.
module tb_store_size_unit;
  import store_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  store_size_unit_if #(.ADDR_W(64), .DATA_W(64)) if1 ();
  store_size_unit_if #(.ADDR_W(64), .DATA_W(64)) if3 ();

  store_size_unit #(.ADDR_W(64), .DATA_W(64), .MEM_RD_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  store_size_unit #(.ADDR_W(64), .DATA_W(64), .MEM_RD_LAT(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3.slave)
  );

  task automatic clear_inputs();
    if1.start = 0; if1.tam = 0; if1.addr = 0; if1.wdata = 0; if1.mem_rdata = 0;
    if3.start = 0; if3.tam = 0; if3.addr = 0; if3.wdata = 0; if3.mem_rdata = 0;
  endtask

  task automatic test_reset();
    logic [9:0] o1, o3;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if1.busy, if3.busy} !== 2'b00) begin
      n_bad++; $display("FAIL reset_idle_busy: got %b want 00", {if1.busy, if3.busy});
    end
    // Random traffic, then reset while the units may be active.
    if1.start = 1; if1.tam = 2'($urandom); if1.addr = {$urandom, $urandom};
    if1.wdata = {$urandom, $urandom}; if1.mem_rdata = {$urandom, $urandom};
    if3.start = 1; if3.tam = 2'b11; if3.addr = {$urandom, $urandom};
    if3.wdata = {$urandom, $urandom}; if3.mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    reset = 1'b1;
    #1;
    o1 = {if1.busy, if1.done, if1.mem_we, if1.misalign, 6'b0};
    o3 = {if3.busy, if3.done, if3.mem_we, if3.misalign, 6'b0};
    n_cmp++;
    if ({o1, o3} !== 20'h0) begin
      n_bad++; $display("FAIL reset_ctrl: got %h want 0", {o1, o3});
    end
    n_cmp++;
    if ((if1.mem_addr | if1.mem_wdata | if3.mem_addr | if3.mem_wdata) !== 64'h0) begin
      n_bad++; $display("FAIL reset_bus: got %h/%h want 0", if1.mem_addr, if3.mem_wdata);
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({if1.busy, if3.busy} !== 2'b00) begin
        n_bad++; $display("FAIL reset_release_busy: got %b want 00", {if1.busy, if3.busy});
      end
    end
  endtask

  task automatic test_sd();
    if1.tam = 2'b00; if1.addr = 64'h108; if1.wdata = 64'h1122334455667788; if1.start = 1;
    @(negedge clk);
    if1.start = 0;
    n_cmp++;
    if ({if1.mem_we, if1.done, if1.busy} !== 3'b111) begin
      n_bad++; $display("FAIL sd_c1_ctrl: got %b want 111", {if1.mem_we, if1.done, if1.busy});
    end
    n_cmp++;
    if (if1.mem_addr !== 64'h108) begin
      n_bad++; $display("FAIL sd_addr: got %h want 108", if1.mem_addr);
    end
    n_cmp++;
    if (if1.mem_wdata !== 64'h1122334455667788) begin
      n_bad++; $display("FAIL sd_wdata: got %h want 1122334455667788", if1.mem_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({if1.mem_we, if1.busy, if1.done} !== 3'b000 || (if1.mem_addr | if1.mem_wdata) !== 64'h0)
    begin
      n_bad++; $display("FAIL sd_c2_idle: got we=%b busy=%b addr=%h wdata=%h want 0",
                        if1.mem_we, if1.busy, if1.mem_addr, if1.mem_wdata);
    end
  endtask

  task automatic test_sb();
    if1.tam = 2'b11; if1.addr = 64'h103; if1.wdata = 64'hEF;
    if1.mem_rdata = 64'hAAAAAAAAAAAAAAAA; if1.start = 1;
    @(negedge clk);
    if1.start = 0;
    n_cmp++;
    if ({if1.busy, if1.mem_we, if1.done} !== 3'b100 || if1.mem_addr !== 64'h100) begin
      n_bad++; $display("FAIL sb_rd: got busy/we/done=%b addr=%h want 100 addr=100",
                        {if1.busy, if1.mem_we, if1.done}, if1.mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({if1.mem_we, if1.done} !== 2'b11) begin
      n_bad++; $display("FAIL sb_wr_ctrl: got %b want 11", {if1.mem_we, if1.done});
    end
    n_cmp++;
    if (if1.mem_wdata !== 64'hAAAAAAAAEFAAAAAA) begin
      n_bad++; $display("FAIL sb_wdata: got %h want AAAAAAAAEFAAAAAA", if1.mem_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_partial_lat3(input logic [1:0] tam, input logic [63:0] addr,
                                   input logic [63:0] wdata, input logic [63:0] rdata,
                                   input logic [63:0] exp_addr, input logic [63:0] exp_wdata);
    if3.tam = tam; if3.addr = addr; if3.wdata = wdata; if3.mem_rdata = rdata; if3.start = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if3.start = 0;
      n_cmp++;
      if (if3.mem_we !== (c == 4) || if3.busy !== (c <= 4)) begin
        n_bad++; $display("FAIL lat3_cycle%0d: got we=%b busy=%b want we=%b busy=%b",
                          c, if3.mem_we, if3.busy, c == 4, c <= 4);
      end
      if (c == 4) begin
        n_cmp++;
        if (if3.mem_wdata !== exp_wdata || if3.mem_addr !== exp_addr || if3.done !== 1'b1) begin
          n_bad++; $display("FAIL lat3_wr: got addr=%h wdata=%h done=%b want %h %h 1",
                            if3.mem_addr, if3.mem_wdata, if3.done, exp_addr, exp_wdata);
        end
      end
    end
  endtask

  task automatic test_misalign(input logic [1:0] tam, input logic [63:0] addr);
    if1.tam = tam; if1.addr = addr; if1.wdata = 64'h1234; if1.start = 1;
    @(negedge clk);
    if1.start = 0;
    n_cmp++;
    if ({if1.misalign, if1.done, if1.mem_we, if1.busy} !== 4'b1101) begin
      n_bad++; $display("FAIL misalign_c1 %h: got %b want 1101", addr,
                        {if1.misalign, if1.done, if1.mem_we, if1.busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({if1.misalign, if1.done, if1.mem_we, if1.busy} !== 4'b0000) begin
      n_bad++; $display("FAIL misalign_c2 %h: got %b want 0000", addr,
                        {if1.misalign, if1.done, if1.mem_we, if1.busy});
    end
  endtask

  task automatic test_start_while_busy();
    if3.tam = 2'b11; if3.addr = 64'h301; if3.wdata = 64'h55; if3.mem_rdata = 64'h0;
    if3.start = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if3.tam = 2'b00; if3.addr = 64'h400; if3.wdata = 64'h66;
      end
      if3.start = (c <= 4);
      n_cmp++;
      if (if3.mem_we !== (c == 4) || if3.busy !== (c <= 4)) begin
        n_bad++; $display("FAIL busy_start_cycle%0d: got we=%b busy=%b want we=%b busy=%b",
                          c, if3.mem_we, if3.busy, c == 4, c <= 4);
      end
      if (c == 4) begin
        n_cmp++;
        if (if3.mem_addr !== 64'h300 || if3.mem_wdata !== 64'h5500) begin
          n_bad++; $display("FAIL busy_start_wr: got addr=%h wdata=%h want 300 5500",
                            if3.mem_addr, if3.mem_wdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_rd();
    if3.tam = 2'b01; if3.addr = 64'h208; if3.wdata = 64'hCAFE; if3.start = 1;
    repeat (2) begin
      @(negedge clk);
      if3.start = 0;
    end
    n_cmp++;
    if ({if3.busy, if3.mem_we} !== 2'b10) begin
      n_bad++; $display("FAIL rst_rd_pre: got %b want 10", {if3.busy, if3.mem_we});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({if3.busy, if3.mem_we, if3.done} !== 3'b000) begin
      n_bad++; $display("FAIL rst_rd_now: got %b want 000", {if3.busy, if3.mem_we, if3.done});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if3.mem_we, if3.done} !== 2'b00) begin
        n_bad++; $display("FAIL rst_rd_after%0d: got %b want 00", c, {if3.mem_we, if3.done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sd();
    test_sb();
    test_partial_lat3(2'b01, 64'h204, 64'hDEADBEEF, 64'h0, 64'h200, 64'hDEADBEEF00000000);
    test_partial_lat3(2'b10, 64'h20A, 64'h1234, 64'hFFFFFFFFFFFFFFFF, 64'h208,
                      64'hFFFFFFFF1234FFFF);
    test_misalign(2'b10, 64'h101);
    test_misalign(2'b01, 64'h102);
    test_start_while_busy();
    test_reset_mid_rd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
